// File: rtl/vote_pkg.sv
// Shared definitions for the vote collector: voter count and round state encoding.
package vote_pkg;

    localparam int unsigned N_VOTERS = 4;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        DONE
    } state_e;

endpackage

// File: rtl/vote_sync.sv
// Two-stage per-bit synchronizer for asynchronous voter buttons.
module vote_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/vote_collector.sv
// Voting round collector: opens a timed window, accumulates "yes" votes, presents a latched ballot.
// Define VOTE_BTN_SYNC_EN to pass the buttons through a 2-flop synchronizer (2-cycle lag).
module vote_collector
    import vote_pkg::*;
#(
    parameter int unsigned WINDOW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] btn,
    input  logic                ballot_ack,
    output logic [N_VOTERS-1:0] ballot,
    output logic                ballot_valid,
    output logic [N_VOTERS-1:0] voted,
    output logic                busy
);

    localparam int unsigned CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] WINDOW_LOAD = CW'(WINDOW);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [N_VOTERS-1:0] ballot_q, ballot_d;

    logic [N_VOTERS-1:0] btn_s;
    logic [N_VOTERS-1:0] voted_acc;
    logic [CW-1:0]       cnt_dec;
    logic                close;

`ifdef VOTE_BTN_SYNC_EN
    vote_sync #(.WIDTH(N_VOTERS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_s)
    );
`else
    assign btn_s = btn;
`endif

    // Round-closing condition is computed once so both the FSM and ballot latch see the same decision.
    always_comb begin
        voted_acc = voted_q | btn_s;
        cnt_dec   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        close     = (cnt_dec == '0) || (voted_acc == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            voted_q  <= '0;
            ballot_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            voted_q  <= voted_d;
            ballot_q <= ballot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = OPEN;
            OPEN:    if (close) state_d = DONE;
            DONE:    if (ballot_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        voted_d  = voted_q;
        ballot_d = ballot_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    voted_d = '0;
                    cnt_d   = WINDOW_LOAD;
                end
            end
            OPEN: begin
                voted_d = voted_acc;
                cnt_d   = cnt_dec;
                if (close) ballot_d = voted_acc;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy         = (state_q == OPEN);
        ballot_valid = (state_q == DONE);
        ballot       = ballot_q;
        voted        = voted_q;
    end

endmodule

// File: tb/tb_vote_collector.sv
// Scoreboard bench for vote_collector: directed rounds push expected ballots, a monitor checks them.
module tb_vote_collector;

`ifdef VOTE_BTN_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ballot_ack = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] ballot, voted;
    logic       ballot_valid, busy;

    logic       start1 = 1'b0;
    logic       ack1 = 1'b0;
    logic [3:0] ballot1, voted1;
    logic       valid1, busy1;

    always #5 clk = ~clk;

    vote_collector #(.WINDOW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .btn          (btn),
        .ballot_ack   (ballot_ack),
        .ballot       (ballot),
        .ballot_valid (ballot_valid),
        .voted        (voted),
        .busy         (busy)
    );

    vote_collector #(.WINDOW(1)) u_w1 (
        .clk          (clk),
        .rst          (rst),
        .start        (start1),
        .btn          (btn),
        .ballot_ack   (ack1),
        .ballot       (ballot1),
        .ballot_valid (valid1),
        .voted        (voted1),
        .busy         (busy1)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] ballot;
        int         len;
        string      name;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] b, input int len, input string name);
        exp_t e;
        e.ballot = b;
        e.len    = len;
        e.name   = name;
        sb.push_back(e);
    endtask

    // Monitor: counts OPEN cycles and checks each new ballot against the scoreboard.
    int   open_cnt = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            open_cnt   = 0;
            prev_valid = 1'b0;
        end else begin
            if (busy) open_cnt++;
            if (ballot_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ballot_valid", 32'(ballot_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_ballot"}, 32'(ballot), 32'(e.ballot));
                    chk({e.name, "_len"}, 32'(open_cnt), 32'(e.len));
                end
                open_cnt = 0;
            end
            prev_valid = ballot_valid;
        end
    end

    task automatic wait_valid(input string name);
        int n = 0;
        while (!ballot_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_reach_done"}, 32'(ballot_valid), 32'd1);
    endtask

    task automatic do_ack();
        ballot_ack = 1'b1;
        @(negedge clk);
        ballot_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_last;
        exp_last = (LAG == 0) ? 4'b0010 : 4'b0000;

        repeat (2) @(negedge clk);
        chk("rst_ballot", 32'(ballot), 32'd0);
        chk("rst_valid", 32'(ballot_valid), 32'd0);
        chk("rst_voted", 32'(voted), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Basic round, start presented with the very first edge after reset release.
        rst   = 1'b0;
        start = 1'b1;
        push(4'b0101, 4, "basic");
        @(negedge clk);
        chk("first_edge_start_busy", 32'(busy), 32'd1);
        start = 1'b0;
        btn   = 4'b0101;
        @(negedge clk);
        btn = 4'b0000;
        wait_valid("basic");
        chk("done_busy_low", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_ballot", 32'(ballot), 32'h5);
            chk("hold_valid", 32'(ballot_valid), 32'd1);
        end
        ballot_ack = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        ballot_ack = 1'b0;
        start      = 1'b0;
        chk("ack_valid_drop", 32'(ballot_valid), 32'd0);
        chk("start_with_ack_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ballot_retained", 32'(ballot), 32'h5);

        // Early close when all four voters are in.
        push(4'b1111, 2 + LAG, "early_close");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        btn = 4'b1111;
        @(negedge clk);
        btn = 4'b0000;
        wait_valid("early_close");
        chk("early_voted", 32'(voted), 32'hf);
        do_ack();

        // Ignored events: btn and ack in IDLE, start in OPEN, btn in DONE.
        btn        = 4'b1000;
        ballot_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_btn_ballot", 32'(ballot), 32'hf);
        chk("idle_ack_busy", 32'(busy), 32'd0);
        btn        = 4'b0000;
        ballot_ack = 1'b0;
        repeat (3) @(negedge clk);
        push(4'b0000, 4, "ignored");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("ignored");
        btn = 4'b1000;
        repeat (3) @(negedge clk);
        chk("done_btn_ballot", 32'(ballot), 32'd0);
        chk("done_btn_valid", 32'(ballot_valid), 32'd1);
        btn = 4'b0000;
        do_ack();
        repeat (3) @(negedge clk);

        // Press in the last OPEN cycle, then the same press three cycles earlier.
        push(exp_last, 4, "last_cycle");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        btn = 4'b0010;
        @(negedge clk);
        btn = 4'b0000;
        wait_valid("last_cycle");
        do_ack();
        repeat (3) @(negedge clk);

        push(4'b0010, 4, "early_pulse");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        btn   = 4'b0010;
        @(negedge clk);
        btn = 4'b0000;
        wait_valid("early_pulse");
        do_ack();
        repeat (3) @(negedge clk);

        // Reset mid-round discards the round without a ballot pulse.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        btn   = 4'b0011;
        @(negedge clk);
        btn = 4'b0000;
        repeat (2) @(negedge clk);
        chk("pre_reset_voted", 32'(voted), 32'h3);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ballot", 32'(ballot), 32'd0);
        chk("async_rst_valid", 32'(ballot_valid), 32'd0);
        chk("async_rst_voted", 32'(voted), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_valid", 32'(ballot_valid), 32'd0);

        // WINDOW=1 instance: exactly one OPEN cycle.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        chk("w1_busy_done", 32'(busy1), 32'd0);
        chk("w1_valid", 32'(valid1), 32'd1);
        chk("w1_ballot", 32'(ballot1), 32'd0);
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
        chk("w1_valid_drop", 32'(valid1), 32'd0);
        chk("w1_voted", 32'(voted1), 32'd0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vote_collector.md
VOTE_COLLECTOR -- requirements
Module: vote_collector

Interface
REQ-001 The block SHALL have parameter WINDOW, default 16, giving the voting-window length in clock cycles (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to open a new voting round; honoured only in IDLE.
REQ-005 btn  input  4  per-voter "yes" buttons; bit k belongs to voter k.
REQ-006 ballot_ack  input  1  downstream voter stage has consumed the ballot.
REQ-007 ballot  output  4  latched ballot vector, wired directly to the voter stage's 4-bit I input.
REQ-008 ballot_valid  output  1  ballot is final and stable.
REQ-009 voted  output  4  voters who have cast "yes" in the current round.
REQ-010 busy  output  1  high while a round is OPEN.

Function
REQ-011 The block SHALL implement three states: IDLE, OPEN and DONE.
REQ-012 IDLE->OPEN on start=1: clear voted, load window counter with WINDOW, and assert busy from the next cycle.
REQ-013 In OPEN, each cycle, voted SHALL update as voted | btn_s, where btn_s is the conditioned button vector; a voter's bit, once set, SHALL never clear within the round.
REQ-014 In OPEN, the window counter SHALL decrement by 1 per cycle and SHALL saturate at 0.
REQ-015 OPEN->DONE when the counter reaches 0 or voted becomes 4'b1111 (early close), whichever occurs first.
REQ-016 On entry to DONE: ballot <= final voted value including any press sampled in the closing cycle; ballot_valid=1 from the first DONE cycle; busy=0.
REQ-017 In DONE, ballot and ballot_valid SHALL hold stable until ballot_ack=1, then DONE->IDLE, and ballot_valid SHALL drop on the next cycle.
REQ-018 ballot SHALL retain its last value in IDLE and SHALL change only on entry to DONE.
REQ-019 start in OPEN or DONE SHALL be ignored, not queued, including when start=1 and ballot_ack=1 occur in the same DONE cycle.
REQ-020 ballot_ack outside DONE SHALL be ignored.
REQ-021 btn activity outside OPEN SHALL have no effect on voted or ballot.
REQ-022 The counter SHALL be $clog2(WINDOW+1) bits wide, unsigned, with no wrap-around.
REQ-023 With WINDOW=1, the round SHALL last exactly one OPEN cycle.

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE, ballot=0, ballot_valid=0, voted=0, busy=0, counter=0, and synchronizer flops=0.
REQ-025 rst asserted mid-round (OPEN or DONE) SHALL discard the round with no ballot_valid pulse.
REQ-026 After rst deasserts, the block SHALL accept start on the first clock edge.

Configuration
REQ-027 With macro VOTE_BTN_SYNC_EN defined, btn SHALL pass through a 2-flop synchronizer per bit, so btn_s lags btn by 2 cycles.
REQ-028 Without VOTE_BTN_SYNC_EN, btn_s SHALL equal btn (zero latency); all other behaviour is identical.

Structure
REQ-029 Shared package vote_pkg SHALL hold N_VOTERS=4 and the state enum {IDLE, OPEN, DONE}.
REQ-030 The synchronizer SHALL be a sub-module vote_sync (parameterized width, 2 stages), instantiated only under VOTE_BTN_SYNC_EN.

Verification
REQ-031 No-sync build, WINDOW=4: start, then btn=4'b0101 held 1 cycle -> after 4 OPEN cycles ballot=4'b0101, ballot_valid=1, busy=0.
REQ-032 Early close: btn=4'b1111 on the 2nd OPEN cycle -> DONE on the next cycle with ballot=4'b1111, before WINDOW expires.
REQ-033 Handshake: hold ballot_ack=0 for 10 cycles in DONE -> ballot and ballot_valid stable; ack=1 -> IDLE, and ballot_valid=0 the following cycle.
REQ-034 Ignored events: start during OPEN, and btn=4'b1000 in IDLE -> round length unchanged and ballot bit 3 = 0.
REQ-035 Reset in OPEN with voted=4'b0011 -> all outputs 0 immediately, and no ballot_valid pulse.
REQ-036 VOTE_BTN_SYNC_EN build, WINDOW=4: btn=4'b0010 pulsed on the last OPEN cycle -> not counted (2-cycle lag); the same pulse 3 cycles earlier -> ballot=4'b0010.
